alu_result_tx_ctrl: RTL
=======================

Name: alu_result_tx_ctrl

Overview:
- Consumer end of the arithmetic unit's result interface. Captures each valid registered ALU result (16-bit result plus valid flag).
- Serialises the captured result into bytes for the UART transmitter: low byte first, then high byte.
- Sits between the ALU and the UART TX in the full system. Paces transmission using a valid/busy handshake with the TX.

Parameters:
- DATA_WIDTH, 8, UART frame payload width.
- RES_WIDTH, 16, ALU result width. Must equal 2*DATA_WIDTH; no other ratio is supported.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous active-low reset.
- ALU_OUT  input  RES_WIDTH  ALU result; sampled only when ALU_OUT_VLD=1.
- ALU_OUT_VLD  input  1  result-valid flag, one cycle per result.
- TX_BUSY  input  1  UART TX busy; high while a frame is in progress.
- TX_P_DATA  output  DATA_WIDTH  byte to transmit; registered.
- TX_D_VLD  output  1  one-cycle strobe requesting TX of TX_P_DATA; registered.
- CTRL_BUSY  output  1  high in every state except IDLE.
- DROP  output  1  one-cycle pulse when an incoming result is discarded.

Behaviour:
- Reset (RST=0, async, any state): state=IDLE, TX_P_DATA=0, TX_D_VLD=0, CTRL_BUSY=0, DROP=0, result register=0, seen_busy=0.
- On reset release, IDLE is entered with no pending data. A transfer in progress is abandoned, with no partial byte re-sent.
- States: IDLE, SEND_LO, WAIT_LO, SEND_HI, WAIT_HI.
- IDLE:
  - If ALU_OUT_VLD=1, capture ALU_OUT into the result register and go to SEND_LO.
  - Otherwise hold.
- SEND_LO:
  - If TX_BUSY=0: TX_P_DATA<=res[DATA_WIDTH-1:0], TX_D_VLD<=1, seen_busy<=0, go to WAIT_LO.
  - If TX_BUSY=1: hold, TX_D_VLD=0.
- WAIT_LO:
  - TX_D_VLD<=0.
  - seen_busy<=1 when TX_BUSY=1.
  - Go to SEND_HI when seen_busy=1 and TX_BUSY=0, i.e. on the falling edge of busy after it was seen high.
- SEND_HI: as SEND_LO, but with res[RES_WIDTH-1:DATA_WIDTH]; goes to WAIT_HI.
- WAIT_HI: as WAIT_LO; exits to IDLE, or to SEND_LO if a pending result exists (see Optional Feature).
- Latency:
  - ALU_OUT_VLD sampled at edge k with TX idle: TX_D_VLD=1 exactly during the cycle after edge k+1.
  - TX_P_DATA holds its value until the next send; it is not cleared after the strobe.
- TX_D_VLD is never high for more than one consecutive cycle.
- ALU_OUT_VLD while not IDLE (feature off): result ignored, DROP=1 for the next cycle, current transfer unaffected.
- ALU_OUT_VLD in the same cycle as the WAIT_HI→IDLE exit: still treated as non-IDLE, so it is dropped (feature off).
- TX_BUSY already high in WAIT_x on entry: seen_busy is set that cycle; normal exit follows.
- TX_BUSY never rising keeps the block in WAIT_x indefinitely. There is no timeout; the system relies on the TX always acknowledging.
- CTRL_BUSY is combinational from state (state!=IDLE).

Optional Feature:
- Macro: ALU_TX_PENDING_BUF_EN.
- Defined:
  - Adds a one-entry pending register plus valid bit.
  - ALU_OUT_VLD while not IDLE and pending empty: store result, no DROP.
  - Pending full: DROP pulse, new result discarded, pending keeps the older value.
  - WAIT_HI exit with pending valid: load pending into the result register, clear pending, go to SEND_LO (no IDLE cycle).
  - ALU_OUT_VLD on that same exit cycle with pending valid: the new result is written into the now-freed pending slot, not dropped.
  - CTRL_BUSY also stays high while pending is valid.
  - Reset clears pending valid.
- Undefined: behaviour exactly as in Behaviour; no pending storage is synthesised.

Decomposition:
- Shared package:
  - State encoding localparams (IDLE=3'd0, SEND_LO=3'd1, WAIT_LO=3'd2, SEND_HI=3'd3, WAIT_HI=3'd4).
  - DATA_WIDTH/RES_WIDTH defaults.
- Natural sub-module: alu_tx_byte_handshake. Implements one SEND/WAIT pair with the seen_busy tracker; instantiated once and sequenced by the top FSM with a byte-select.
- Pending buffer stays inline under the macro.

Test Plan:
- ALU_OUT=16'hA55A, ALU_OUT_VLD pulse, TX idle, TX model asserts busy 1 cycle after strobe for 10 cycles → strobe with TX_P_DATA=8'h5A, then strobe with 8'hA5 after busy falls, then CTRL_BUSY=0.
- TX_BUSY held high before the result arrives → no TX_D_VLD until TX_BUSY=0; strobe appears 1 cycle after the fall.
- Second ALU_OUT_VLD (16'h1234) during WAIT_LO, feature off → DROP=1 for one cycle; only 8'h5A and 8'hA5 transmitted.
- Feature on, three results 16'h0102, 16'h0304, 16'h0506 back-to-back → bytes sent 02,01,04,03; DROP pulses once, for 16'h0506.
- RST asserted mid-WAIT_LO → all outputs 0 immediately (async); after release, a new result 16'hFF00 sends 00 then FF.
- Result 16'h0000 and 16'hFFFF → bytes sent 00,00 and FF,FF; TX_D_VLD never high for two consecutive cycles.

Source files
------------

// File: rtl/alu_result_tx_ctrl_pkg.sv
// Shared types and defaults for the ALU result to UART TX byte serialiser.
// State encoding and width defaults used by the top and the byte handshake.
package alu_result_tx_ctrl_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int RES_WIDTH_DEF  = 16;

  typedef logic [2:0] state_t;

  localparam state_t IDLE    = 3'd0;
  localparam state_t SEND_LO = 3'd1;
  localparam state_t WAIT_LO = 3'd2;
  localparam state_t SEND_HI = 3'd3;
  localparam state_t WAIT_HI = 3'd4;

endpackage

// File: rtl/alu_tx_byte_handshake.sv
// One SEND/WAIT byte handshake with the UART TX, shared by low and high bytes.
// Tracks whether TX busy was seen high so WAIT exits on its falling edge.
module alu_tx_byte_handshake
  import alu_result_tx_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int RES_WIDTH  = RES_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  send_en,
  input  logic                  wait_en,
  input  logic                  sel_hi,
  input  logic [RES_WIDTH-1:0]  res,
  input  logic                  tx_busy,
  output logic [DATA_WIDTH-1:0] tx_p_data,
  output logic                  tx_d_vld,
  output logic                  sent,
  output logic                  done
);

  logic                  seen_busy;
  logic [DATA_WIDTH-1:0] byte_sel;

  assign byte_sel = sel_hi ? res[RES_WIDTH-1:DATA_WIDTH]
                           : res[DATA_WIDTH-1:0];
  assign sent     = send_en & ~tx_busy;
  assign done     = wait_en & seen_busy & ~tx_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_p_data <= '0;
      tx_d_vld  <= 1'b0;
      seen_busy <= 1'b0;
    end else begin
      tx_d_vld <= sent;
      if (sent) begin
        tx_p_data <= byte_sel;
        seen_busy <= 1'b0;
      end else if (wait_en && tx_busy) begin
        seen_busy <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_result_tx_ctrl.sv
// Captures ALU results and sends them to the UART TX low byte then high byte.
// Define ALU_TX_PENDING_BUF_EN to add a one-entry pending result buffer.
module alu_result_tx_ctrl
  import alu_result_tx_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int RES_WIDTH  = RES_WIDTH_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [RES_WIDTH-1:0]  ALU_OUT,
  input  logic                  ALU_OUT_VLD,
  input  logic                  TX_BUSY,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_D_VLD,
  output logic                  CTRL_BUSY,
  output logic                  DROP
);

  state_t                 state;
  state_t                 state_nxt;
  logic [RES_WIDTH-1:0]   res;
  logic [RES_WIDTH-1:0]   pend;
  logic                   pend_vld;
  logic                   sent;
  logic                   done;
  logic                   hi_done;
  logic                   send_en;
  logic                   wait_en;
  logic                   sel_hi;
  logic                   take;
  logic                   load_new;
  logic                   drop_nxt;

  assign hi_done = (state == WAIT_HI) & done;

`ifdef ALU_TX_PENDING_BUF_EN
  logic store;

  assign take     = pend_vld & ((state == IDLE) | hi_done);
  assign store    = ALU_OUT_VLD & ((state != IDLE) | pend_vld);
  assign load_new = ALU_OUT_VLD & (state == IDLE) & ~pend_vld;
  assign drop_nxt = store & pend_vld & ~take;

  // A slot freed by take can accept a result arriving in the same cycle
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pend     <= '0;
      pend_vld <= 1'b0;
    end else if (store && (!pend_vld || take)) begin
      pend     <= ALU_OUT;
      pend_vld <= 1'b1;
    end else if (take) begin
      pend_vld <= 1'b0;
    end
  end
`else
  assign pend     = '0;
  assign pend_vld = 1'b0;
  assign take     = 1'b0;
  assign load_new = ALU_OUT_VLD & (state == IDLE);
  assign drop_nxt = ALU_OUT_VLD & (state != IDLE);
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
      res   <= '0;
      DROP  <= 1'b0;
    end else begin
      state <= state_nxt;
      DROP  <= drop_nxt;
      if (take) begin
        res <= pend;
      end else if (load_new) begin
        res <= ALU_OUT;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (pend_vld || ALU_OUT_VLD) state_nxt = SEND_LO;
      SEND_LO: if (sent) state_nxt = WAIT_LO;
      WAIT_LO: if (done) state_nxt = SEND_HI;
      SEND_HI: if (sent) state_nxt = WAIT_HI;
      WAIT_HI: if (done) state_nxt = pend_vld ? SEND_LO : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    CTRL_BUSY = (state != IDLE) | pend_vld;
    send_en   = (state == SEND_LO) | (state == SEND_HI);
    wait_en   = (state == WAIT_LO) | (state == WAIT_HI);
    sel_hi    = (state == SEND_HI);
  end

  alu_tx_byte_handshake #(
    .DATA_WIDTH (DATA_WIDTH),
    .RES_WIDTH  (RES_WIDTH)
  ) u_hs (
    .clk       (CLK),
    .rst_n     (RST),
    .send_en   (send_en),
    .wait_en   (wait_en),
    .sel_hi    (sel_hi),
    .res       (res),
    .tx_busy   (TX_BUSY),
    .tx_p_data (TX_P_DATA),
    .tx_d_vld  (TX_D_VLD),
    .sent      (sent),
    .done      (done)
  );

endmodule
